// File: rtl/binoc_ni_ejector.sv
// binoc_ni_ejector: NI receive side; credit-flow FIFO, framing/destination check,
// valid/ready flit delivery to the core with packet and error counters.
module binoc_ni_ejector #(
  parameter int COORD_W = 1,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int FLIT_W  = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_W-1:0]    flit_in,
  input  logic                 flit_valid,
  output logic                 credit_out,
  output logic [31:0]          core_data,
  output logic [2*COORD_W-1:0] core_src,
  output logic                 core_sop,
  output logic                 core_eop,
  output logic                 core_valid,
  input  logic                 core_ready,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_dst,
  output logic                 err_proto
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;
  state_t state, state_nx;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [FLIT_W-1:0] head;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [2*COORD_W-1:0] src_q;
  logic empty, full, push, pop, hs, is_head, is_tail, dst_ok;
  logic deliver, discard, f_dst, f_proto, ovf;
  logic [1:0] err_inc;
  logic [CNT_W:0] err_sum, pkt_sum;

  assign head    = mem[rp];
  assign empty   = cnt == '0;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign is_head = head[FLIT_W-1];
  assign is_tail = head[FLIT_W-2];
  assign dst_ok  = head[31 -: COORD_W] == COORD_W'(MY_X) &&
                   head[31-COORD_W -: COORD_W] == COORD_W'(MY_Y);

  // A head seen mid-packet or while dropping is left in the FIFO and re-examined from IDLE
  always_comb begin
    deliver  = 1'b0;
    discard  = 1'b0;
    f_dst    = 1'b0;
    f_proto  = 1'b0;
    state_nx = state;
    if (!empty)
      case (state)
        IDLE:
          if (is_head && dst_ok) begin
            deliver = 1'b1;
            if (core_ready && !is_tail) state_nx = BODY;
          end else if (is_head) begin
            discard = 1'b1;
            f_dst   = 1'b1;
            if (!is_tail) state_nx = DROP;
          end else begin
            discard = 1'b1;
            f_proto = 1'b1;
          end
        BODY:
          if (is_head) begin
            f_proto  = 1'b1;
            state_nx = IDLE;
          end else begin
            deliver = 1'b1;
            if (core_ready && is_tail) state_nx = IDLE;
          end
        DROP:
          if (is_head) begin
            f_proto  = 1'b1;
            state_nx = IDLE;
          end else begin
            discard = 1'b1;
            if (is_tail) state_nx = IDLE;
          end
        default: state_nx = IDLE;
      endcase
  end

  assign hs         = deliver & core_ready;
  assign pop        = hs | discard;
  assign push       = flit_valid & (~full | pop);
  assign ovf        = flit_valid & full & ~pop;
  assign core_valid = deliver;
  assign core_sop   = deliver && state == IDLE;
  assign core_eop   = deliver & is_tail;
  assign core_data  = empty ? '0 : head[31:0];
  assign core_src   = core_sop ? head[31-2*COORD_W -: 2*COORD_W] : src_q;
  assign err_inc    = 2'(f_dst) + 2'(f_proto) + 2'(ovf);
  assign err_sum    = {1'b0, err_cnt} + (CNT_W+1)'(err_inc);
  assign pkt_sum    = {1'b0, pkt_cnt} + (CNT_W+1)'(hs & is_tail);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      src_q      <= '0;
      credit_out <= 1'b0;
      err_dst    <= 1'b0;
      err_proto  <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nx;
      wp         <= wp + AW'(push);
      rp         <= rp + AW'(pop);
      cnt        <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (hs && state == IDLE) src_q <= head[31-2*COORD_W -: 2*COORD_W];
      credit_out <= pop;
      err_dst    <= f_dst;
      err_proto  <= f_proto | ovf;
      pkt_cnt    <= pkt_sum[CNT_W] ? '1 : pkt_sum[CNT_W-1:0];
      err_cnt    <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end

  always_ff @(posedge clk)
    if (push) mem[wp] <= flit_in;
endmodule

// File: tb/tb_binoc_ni_ejector.sv
// tb_binoc_ni_ejector: directed scenarios plus credit-respecting random traffic
// checked against a flit-sequence parser model of the packet rules.
module tb_binoc_ni_ejector;
  localparam logic [1:0] HD = 2'b10, BD = 2'b00, TL = 2'b01, HT = 2'b11;
  logic clk = 1'b0, rst = 1'b0, flit_valid = 1'b0, core_ready = 1'b0;
  logic [33:0] flit_in = '0;
  logic credit_out, core_sop, core_eop, core_valid, err_dst, err_proto;
  logic [31:0] core_data;
  logic [1:0] core_src;
  logic [15:0] pkt_cnt, err_cnt;
  int vectors = 0, miscompares = 0;
  int cr, mode, e_pkt, e_err, e_dst, e_proto, n_dst, n_proto;
  logic [1:0] cur_src;
  logic [35:0] expq[$];
  logic [33:0] p1h, p1b, p1t, h3, b3a, b3b, t3, x3, hm, bm, tm, h5, b5, ht5, h6, b6, ht6;
  logic [33:0] arr3 [4];

  binoc_ni_ejector dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
    .credit_out(credit_out), .core_data(core_data), .core_src(core_src),
    .core_sop(core_sop), .core_eop(core_eop), .core_valid(core_valid),
    .core_ready(core_ready), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
    .err_dst(err_dst), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [33:0] f, input logic r);
    @(negedge clk);
    flit_valid = v;
    flit_in    = f;
    core_ready = r;
    #1;
  endtask

  function automatic logic [5:0] ctl();
    return {core_valid, core_sop, core_eop, credit_out, core_src};
  endfunction

  function automatic logic [33:0] fl(input logic [1:0] t, input logic [3:0] hdr, input logic [27:0] p);
    return {t, hdr, p};
  endfunction

  function automatic logic [33:0] rnd_flit();
    int r;
    logic [1:0] t;
    logic [31:0] d;
    r = int'($urandom_range(0, 99));
    t = r < 25 ? HD : r < 60 ? BD : r < 80 ? TL : HT;
    d = $urandom;
    if (t[1] && $urandom_range(0, 9) < 6) d[31:30] = 2'b00;
    return {t, d};
  endfunction

  // Packet rules applied to the ordered stream of accepted flits
  task automatic model(input logic [33:0] f);
    logic [1:0] t;
    bit again;
    t = f[33:32];
    do begin
      again = 0;
      if (mode == 0) begin
        if (t[1] && f[31:30] == 2'b00) begin
          expq.push_back({f[31:0], 1'b1, t[0], f[29:28]});
          cur_src = f[29:28];
          if (t[0]) e_pkt++; else mode = 1;
        end else if (t[1]) begin
          e_dst++; e_err++;
          mode = t[0] ? 0 : 2;
        end else begin
          e_proto++; e_err++;
        end
      end else if (t[1]) begin
        e_proto++; e_err++;
        mode = 0; again = 1;
      end else if (mode == 1) begin
        expq.push_back({f[31:0], 1'b0, t[0], cur_src});
        if (t[0]) begin e_pkt++; mode = 0; end
      end else if (t[0]) mode = 0;
    end while (again);
  endtask

  task automatic observe();
    logic [35:0] exp;
    if (credit_out) cr++;
    if (err_dst) n_dst++;
    if (err_proto) n_proto++;
    if (core_valid && core_ready) begin
      exp = expq.size() > 0 ? expq.pop_front() : '1;
      chk("rnd_flit", {core_data, core_sop, core_eop, core_src}, exp);
    end
  endtask

  initial begin
    p1h = fl(HD, 4'b0011, 28'h00000A1); p1b = fl(BD, 4'h5, 28'h12345B2); p1t = fl(TL, 4'hA, 28'h0FEDCC3);
    h3  = fl(HD, 4'b0001, 28'h0000031); b3a = fl(BD, 4'h7, 28'h1111111);
    b3b = fl(BD, 4'h3, 28'h2222222);    t3  = fl(TL, 4'h9, 28'h3333333);
    x3  = fl(TL, 4'hF, 28'h000DEAD);
    hm  = fl(HD, 4'b1000, 28'h0000044); bm = fl(BD, 4'h0, 28'h4444444); tm = fl(TL, 4'h0, 28'h5555555);
    h5  = fl(HD, 4'b0010, 28'h0000055); b5 = fl(BD, 4'h6, 28'h6666666); ht5 = fl(HT, 4'b0001, 28'h0000077);
    h6  = fl(HD, 4'b0011, 28'h0000088); b6 = fl(BD, 4'hB, 28'h7777777); ht6 = fl(HT, 4'b0010, 28'h0000099);
    arr3[0] = b3a; arr3[1] = b3b; arr3[2] = t3; arr3[3] = x3;

    // reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 0);
      chk("idle_ctl", {ctl(), err_dst, err_proto}, 0);
      chk("idle_cnt", {pkt_cnt, err_cnt, core_data}, 0);
    end

    // matching 3-flit packet
    cyc(1, p1h, 1); chk("t2_empty", ctl(), 6'b000000);
    cyc(1, p1b, 1); chk("t2_head", {ctl(), core_data}, {6'b110011, p1h[31:0]});
    cyc(1, p1t, 1); chk("t2_body", {ctl(), core_data}, {6'b100111, p1b[31:0]});
    cyc(0, '0, 1);  chk("t2_tail", {ctl(), core_data}, {6'b101111, p1t[31:0]});
    cyc(0, '0, 1);  chk("t2_done", {ctl(), pkt_cnt}, {6'b000111, 16'd1});
    cyc(0, '0, 1);  chk("t2_quiet", ctl(), 6'b000011);

    // backpressure and overflow
    cyc(1, h3, 0); chk("t3_empty", ctl(), 6'b000011);
    for (int i = 0; i < 4; i++) begin
      cyc(1, arr3[i], 0);
      chk("t3_hold", {ctl(), core_data}, {6'b110001, h3[31:0]});
    end
    cyc(0, '0, 0); chk("t3_ovf", {err_proto, err_cnt, core_data}, {1'b1, 16'd1, h3[31:0]});
    cyc(0, '0, 1); chk("t3_head", {ctl(), err_proto, core_data}, {6'b110001, 1'b0, h3[31:0]});
    cyc(0, '0, 1); chk("t3_b1", {ctl(), core_data}, {6'b100101, b3a[31:0]});
    cyc(0, '0, 1); chk("t3_b2", {ctl(), core_data}, {6'b100101, b3b[31:0]});
    cyc(0, '0, 1); chk("t3_tail", {ctl(), core_data}, {6'b101101, t3[31:0]});
    cyc(0, '0, 1); chk("t3_done", {ctl(), pkt_cnt}, {6'b000101, 16'd2});
    cyc(0, '0, 1); chk("t3_drained", {ctl(), core_data}, {6'b000001, 32'd0});

    // misrouted packet
    cyc(1, hm, 1); chk("t4_empty", ctl(), 6'b000001);
    cyc(1, bm, 1); chk("t4_drop_h", {ctl(), err_dst}, {6'b000001, 1'b0});
    cyc(1, tm, 1); chk("t4_err", {ctl(), err_dst, err_cnt}, {6'b000101, 1'b1, 16'd2});
    cyc(0, '0, 1); chk("t4_drop_b", {ctl(), err_dst}, {6'b000101, 1'b0});
    cyc(0, '0, 1); chk("t4_drop_t", ctl(), 6'b000101);
    cyc(0, '0, 1); chk("t4_end", {ctl(), err_dst, err_proto, err_cnt, pkt_cnt}, {6'b000001, 2'b00, 16'd2, 16'd2});

    // truncated packet followed by a head-tail
    cyc(1, h5, 1);  chk("t5_empty", ctl(), 6'b000001);
    cyc(1, b5, 1);  chk("t5_head", {ctl(), core_data}, {6'b110010, h5[31:0]});
    cyc(1, ht5, 1); chk("t5_body", {ctl(), core_data}, {6'b100110, b5[31:0]});
    cyc(0, '0, 1);  chk("t5_trunc", {ctl(), err_proto}, {6'b000110, 1'b0});
    cyc(0, '0, 1);  chk("t5_ht", {ctl(), err_proto, err_cnt, core_data}, {6'b111001, 1'b1, 16'd3, ht5[31:0]});
    cyc(0, '0, 1);  chk("t5_done", {ctl(), err_proto, pkt_cnt}, {6'b000101, 1'b0, 16'd3});

    // reset mid-packet
    cyc(1, h6, 0);
    cyc(1, b6, 0); chk("t6_pre", ctl(), 6'b110011);
    @(negedge clk);
    flit_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk("t6_rst", {ctl(), err_dst, err_proto, pkt_cnt, err_cnt, core_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, ht6, 1); chk("t6_empty", {ctl(), core_data}, 0);
    cyc(0, '0, 1);  chk("t6_ht", {ctl(), core_data}, {6'b111010, ht6[31:0]});
    cyc(0, '0, 1);  chk("t6_done", {ctl(), pkt_cnt, err_cnt}, {6'b000110, 16'd1, 16'd0});

    // random traffic under upstream credit control
    cr = 4; mode = 0; e_pkt = 1; e_err = 0; e_dst = 0; e_proto = 0; n_dst = 0; n_proto = 0; cur_src = '0;
    for (int k = 0; k < 3000; k++) begin
      logic snd;
      logic [33:0] f;
      @(negedge clk);
      snd = cr > 0 && $urandom_range(0, 2) != 0;
      f = rnd_flit();
      flit_valid = snd;
      flit_in    = f;
      core_ready = $urandom_range(0, 3) != 0;
      #1;
      observe();
      if (snd) begin
        cr--;
        model(f);
      end
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      flit_valid = 1'b0;
      core_ready = 1'b1;
      #1;
      observe();
    end
    chk("rnd_credits", cr, 4);
    chk("rnd_pending", expq.size(), 0);
    chk("rnd_pkt_cnt", pkt_cnt, e_pkt);
    chk("rnd_err_cnt", err_cnt, e_err);
    chk("rnd_err_dst", n_dst, e_dst);
    chk("rnd_err_proto", n_proto, e_proto);
    chk("rnd_idle", core_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/binoc_ni_ejector.md
Name: binoc_ni_ejector

Overview:
- Network-interface receive end of a BiNoc router local port. The router local output is the transmitter; this block is the receiver.
- Accepts flits under credit-based flow control into a small FIFO, then checks packet framing and destination.
- Delivers valid packets to the attached core through a valid/ready flit stream. Drops misrouted or malformed traffic and counts packets and errors.
- One instance sits beside each router of the 2x2 mesh.

Parameters:
- COORD_W, 1, width of one mesh coordinate (x or y)
- MY_X, 0, x coordinate of this node
- MY_Y, 0, y coordinate of this node
- DEPTH, 4, FIFO depth in flits, power of two, minimum 2; equals the upstream initial credit count
- CNT_W, 16, width of the packet and error counters
- FLIT_W, 34, flit width: [33:32] type, [31:0] data

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- flit_in  in  FLIT_W  flit from router local output
- flit_valid  in  1  flit_in is valid this cycle
- credit_out  out  1  one-cycle pulse: one FIFO slot freed
- core_data  out  32  flit data to the core
- core_src  out  2*COORD_W  {src_x,src_y} of the current packet
- core_sop  out  1  core_data is a head flit
- core_eop  out  1  core_data is a tail or head-tail flit
- core_valid  out  1  core_data is valid
- core_ready  in  1  core accepts the flit
- pkt_cnt  out  CNT_W  packets fully delivered; saturates at all-ones
- err_cnt  out  CNT_W  error events; saturates at all-ones
- err_dst  out  1  one-cycle pulse: destination mismatch
- err_proto  out  1  one-cycle pulse: framing violation or overflow

Behaviour:
- Flit types in [33:32]:
  - 2'b10 HEAD
  - 2'b00 BODY
  - 2'b01 TAIL
  - 2'b11 HEADTAIL
- Head data layout, with C = COORD_W:
  - [31 -: C] dst_x
  - [31-C -: C] dst_y
  - [31-2C -: C] src_x
  - [31-3C -: C] src_y
  - the remaining bits are payload
- Reset (rst=0), asynchronous:
  - FIFO emptied, state IDLE
  - credit_out, core_valid, core_sop, core_eop, err_dst, err_proto = 0
  - core_src, pkt_cnt, err_cnt = 0
  - core_data = 0 while the FIFO is empty
  - Reset mid-packet discards all buffered flits and produces no credit pulses.
- FIFO:
  - Pushes flit_in when flit_valid=1.
  - A push while full is also accepted if a pop occurs in the same cycle.
  - A push while full with no pop discards the flit: err_proto pulses and err_cnt increments. FIFO contents are unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: a flit pushed in cycle N can appear on the core outputs in cycle N+1. core_* outputs are combinational from the FIFO head and the state.
- Pop rules:
  - A pop happens on a core handshake (core_valid & core_ready), or when the FSM discards the head flit.
  - Every pop produces exactly one credit_out pulse in the following cycle.
  - core_valid is never asserted for a discarded flit.
- FSM states IDLE, BODY, DROP. Rules apply when the FIFO is non-empty.
  - IDLE, HEAD/HEADTAIL with dst == (MY_X,MY_Y):
    - core_valid=1, core_sop=1; core_eop=1 for HEADTAIL.
    - core_src shows the head's src field combinationally and is registered on the handshake.
    - On handshake: HEAD goes to BODY; HEADTAIL stays IDLE and pkt_cnt increments.
  - IDLE, HEAD/HEADTAIL with dst mismatch:
    - Discard the flit; err_dst pulses and err_cnt increments.
    - HEAD goes to DROP; HEADTAIL stays IDLE.
  - IDLE, BODY/TAIL: discard the flit; err_proto pulses and err_cnt increments; stay IDLE.
  - BODY, BODY flit: deliver with sop=0, eop=0.
  - BODY, TAIL flit: deliver with eop=1. On handshake, pkt_cnt increments and the state goes to IDLE.
  - BODY, HEAD/HEADTAIL (truncated packet):
    - Do not pop; err_proto pulses and err_cnt increments; go to IDLE.
    - The new head is processed on the next cycle.
  - DROP: discard BODY flits. A TAIL is discarded and the state goes to IDLE. HEAD/HEADTAIL: do not pop, go to IDLE, err_proto pulses.
- core_src holds its value from the head handshake until the next delivered head.
- core_data, core_sop and core_eop are stable while core_valid=1 and core_ready=0.
- When overflow and an FSM error fire in the same cycle, err_cnt increments by 2 and err_proto is a single pulse.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release, no stimulus -> all outputs 0, credit_out never pulses.
- Matching 3-flit packet to (0,0) with src (1,1), core_ready=1:
  - core_valid on cycles N+1..N+3
  - sop on the first flit, eop on the third, core_src=2'b11
  - 3 credit pulses, pkt_cnt=1
- Backpressure: push 4 flits with core_ready=0 -> core_data held, no credits. Push a 5th flit -> err_proto pulse, err_cnt=1. Raise core_ready -> 4 flits delivered, 4 credits.
- Misrouted HEAD (dst=(1,0)) followed by BODY, TAIL -> err_dst pulse once, core_valid stays 0, 3 credits, err_cnt=1, final state IDLE.
- Truncation: HEAD, BODY, then HEADTAIL to self -> err_proto pulse, HEADTAIL delivered with sop=1 and eop=1, pkt_cnt=1.
- Mid-packet reset: assert rst after HEAD+BODY with 2 flits buffered -> FIFO empty and counters 0. A new HEADTAIL after reset is delivered normally.
